frequency_analyzer_reader: RTL

FREQUENCY_ANALYZER_READER -- requirements
Module: frequency_analyzer_reader

---
 rtl/frequency_analyzer_reader.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/frequency_analyzer_reader.sv
// AXI4-Lite master that drains a frequency analyzer's histogram on interrupt.
// An irq rising edge starts a burst. The burst reads NUM_REGS consecutive words,
// hands each word downstream with a valid/ready handshake, and then writes
// CLEAR_VALUE to CLEAR_ADDR. All outputs come straight from registers.
module frequency_analyzer_reader #(
    parameter int                                C_M00_AXI_DATA_WIDTH = 32,
    parameter int                                C_M00_AXI_ADDR_WIDTH = 10,
    parameter int                                BASE_ADDR            = 0,
    parameter int                                NUM_REGS             = 8,
    parameter logic [C_M00_AXI_ADDR_WIDTH-1:0]   CLEAR_ADDR           = 10'h3FC,
    parameter logic [31:0]                       CLEAR_VALUE          = 32'h1
) (
    input  logic                              m00_axi_aclk,
    input  logic                              m00_axi_aresetn,
    input  logic                              irq,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                        m00_axi_awprot,
    output logic                              m00_axi_awvalid,
    input  logic                              m00_axi_awready,
    output logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [3:0]                        m00_axi_wstrb,
    output logic                              m00_axi_wvalid,
    input  logic                              m00_axi_wready,
    input  logic [1:0]                        m00_axi_bresp,
    input  logic                              m00_axi_bvalid,
    output logic                              m00_axi_bready,
    output logic [C_M00_AXI_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                        m00_axi_arprot,
    output logic                              m00_axi_arvalid,
    input  logic                              m00_axi_arready,
    input  logic [C_M00_AXI_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                        m00_axi_rresp,
    input  logic                              m00_axi_rvalid,
    output logic                              m00_axi_rready,
    output logic [31:0]                       out_data,
    output logic [7:0]                        out_index,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              done,
    output logic                              error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        PUSH    = 3'd3,
        WR_ADDR = 3'd4,
        WR_RESP = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [C_M00_AXI_ADDR_WIDTH-1:0] BASE_A   = C_M00_AXI_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [8:0]                      LAST_IDX = 9'(NUM_REGS - 1);

    state_t                              state_r, state_s;
    logic [1:0]                          sync_r;
    logic                                edge_prev_r;
    logic                                trig_s;
    logic [7:0]                          index_r, index_s;
    logic                                pending_r, pending_s;
    logic                                error_r, error_s;
    logic [31:0]                         out_data_r, out_data_s;
    logic                                aw_done_r, aw_done_s;
    logic                                w_done_r, w_done_s;
    logic                                aw_hs_s, w_hs_s;
    logic [C_M00_AXI_ADDR_WIDTH-1:0]     araddr_r, araddr_s;
    logic                                arvalid_r, rready_r, out_valid_r;
    logic                                awvalid_r, wvalid_r, bready_r;
    logic                                busy_r, done_r;

    // Rising edge of the synchronized interrupt; high for exactly one clock.
    assign trig_s = sync_r[1] & ~edge_prev_r;

    // Two-flop synchronizer for irq plus the delayed copy used by the edge detector.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            sync_r      <= 2'b00;
            edge_prev_r <= 1'b0;
        end else begin
            sync_r      <= {sync_r[0], irq};
            edge_prev_r <= sync_r[1];
        end
    end

    // Next-state logic and the next values of the datapath registers.
    always_comb begin
        state_s    = state_r;
        index_s    = index_r;
        pending_s  = pending_r;
        error_s    = error_r;
        out_data_s = out_data_r;
        aw_done_s  = aw_done_r;
        w_done_s   = w_done_r;
        aw_hs_s    = aw_done_r | (awvalid_r & m00_axi_awready);
        w_hs_s     = w_done_r | (wvalid_r & m00_axi_wready);

        // A trigger during a burst is remembered once; extra ones are dropped.
        if (trig_s && (state_r != IDLE)) begin
            pending_s = 1'b1;
        end else begin
            pending_s = pending_r;
        end

        case (state_r)
            IDLE: begin
                if (trig_s || pending_r) begin
                    state_s   = RD_ADDR;
                    index_s   = 8'd0;
                    error_s   = 1'b0;
                    pending_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RD_ADDR: begin
                if (m00_axi_arready) begin
                    state_s = RD_DATA;
                end else begin
                    state_s = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (m00_axi_rvalid) begin
                    out_data_s = m00_axi_rdata[31:0];
                    error_s    = error_r | (m00_axi_rresp != 2'b00);
                    state_s    = PUSH;
                end else begin
                    state_s = RD_DATA;
                end
            end
            PUSH: begin
                if (out_ready) begin
                    if ({1'b0, index_r} < LAST_IDX) begin
                        index_s = index_r + 8'd1;
                        state_s = RD_ADDR;
                    end else begin
                        state_s = WR_ADDR;
                    end
                end else begin
                    state_s = PUSH;
                end
            end
            WR_ADDR: begin
                // Address and data handshakes complete independently, in any order.
                if (aw_hs_s && w_hs_s) begin
                    aw_done_s = 1'b0;
                    w_done_s  = 1'b0;
                    state_s   = WR_RESP;
                end else begin
                    aw_done_s = aw_hs_s;
                    w_done_s  = w_hs_s;
                    state_s   = WR_ADDR;
                end
            end
            WR_RESP: begin
                if (m00_axi_bvalid) begin
                    error_s = error_r | (m00_axi_bresp != 2'b00);
                    state_s = DONE;
                end else begin
                    state_s = WR_RESP;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        araddr_s = BASE_A + C_M00_AXI_ADDR_WIDTH'({index_s, 2'b00});
    end

    // State, datapath and output registers; outputs are decoded from the next state.
    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state_r     <= IDLE;
            index_r     <= 8'd0;
            pending_r   <= 1'b0;
            error_r     <= 1'b0;
            out_data_r  <= 32'd0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            araddr_r    <= '0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            out_valid_r <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            bready_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            index_r     <= index_s;
            pending_r   <= pending_s;
            error_r     <= error_s;
            out_data_r  <= out_data_s;
            aw_done_r   <= aw_done_s;
            w_done_r    <= w_done_s;
            araddr_r    <= araddr_s;
            arvalid_r   <= (state_s == RD_ADDR);
            rready_r    <= (state_s == RD_DATA);
            out_valid_r <= (state_s == PUSH);
            awvalid_r   <= (state_s == WR_ADDR) && !aw_done_s;
            wvalid_r    <= (state_s == WR_ADDR) && !w_done_s;
            bready_r    <= (state_s == WR_RESP);
            busy_r      <= (state_s != IDLE);
            done_r      <= (state_s == DONE);
        end
    end

    assign m00_axi_awaddr  = CLEAR_ADDR;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_r;
    assign m00_axi_wdata   = C_M00_AXI_DATA_WIDTH'(CLEAR_VALUE);
    assign m00_axi_wstrb   = 4'hF;
    assign m00_axi_wvalid  = wvalid_r;
    assign m00_axi_bready  = bready_r;
    assign m00_axi_araddr  = araddr_r;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = arvalid_r;
    assign m00_axi_rready  = rready_r;
    assign out_data        = out_data_r;
    assign out_index       = index_r;
    assign out_valid       = out_valid_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign error           = error_r;

endmodule
